mips_run_sequencer: RTL

Synthesizable run controller that sequences one program run of the MIPS core: holds the core in reset, releases it with a selected forwarding mode, counts executed cycles, and ends the run on halt detection or cycle-budget exhaustion. It sits between the test/host logic and the `MIPS_PROCESSOR` instance and drives that instance's reset and `FORWARDING_EN`. It replaces fixed-delay reset and fixed-length run stimulus with a parametrised, observable handshake.

---
 rtl/mips_run_sequencer_if.sv | 29 ++
 rtl/mips_run_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mips_run_sequencer_if.sv
// Host-side run-control bundle for mips_run_sequencer.
// The master modport drives run requests and the core PC; the slave modport is the sequencer.
interface mips_run_sequencer_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             START;
    logic             ABORT;
    logic             FWD_MODE;
    logic [CNT_W-1:0] MAX_CYCLES;
    logic [PC_W-1:0]  PC;
    logic             CORE_RESET;
    logic             FORWARDING_EN;
    logic             BUSY;
    logic             DONE;
    logic             HALTED;
    logic             TIMEOUT;
    logic [CNT_W-1:0] CYCLE_COUNT;

    modport master (
        output START, ABORT, FWD_MODE, MAX_CYCLES, PC,
        input  CORE_RESET, FORWARDING_EN, BUSY, DONE, HALTED, TIMEOUT, CYCLE_COUNT
    );

    modport slave (
        input  START, ABORT, FWD_MODE, MAX_CYCLES, PC,
        output CORE_RESET, FORWARDING_EN, BUSY, DONE, HALTED, TIMEOUT, CYCLE_COUNT
    );
endinterface

// File: rtl/mips_run_sequencer.sv
// Sequences one MIPS core run: reset hold, run with cycle count, end on PC stall or budget.
// All outputs registered; START is a level request acknowledged by dropping it in DONE.
module mips_run_sequencer #(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 16,
    parameter int RST_HOLD    = 2,
    parameter int STALL_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    mips_run_sequencer_if.slave   bus
);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] budget;
    logic [HW-1:0]    hold_cnt;
    logic [SW-1:0]    stall_cnt;
    logic [PC_W-1:0]  prev_pc;
    logic             prev_vld;

    logic             core_reset_r;
    logic             fwd_r;
    logic             busy_r;
    logic             done_r;
    logic             halted_r;
    logic             timeout_r;
    logic [CNT_W-1:0] cycle_cnt_r;

    logic [CNT_W-1:0] cnt_nxt;
    logic [SW-1:0]    stall_nxt;
    logic             pc_match;
    logic             halt_hit;
    logic             tmo_hit;

    // Counter saturates at all-ones; timeout compares against the post-increment value.
    assign cnt_nxt   = (&cycle_cnt_r) ? cycle_cnt_r : cycle_cnt_r + CNT_W'(1);
    assign pc_match  = prev_vld && (bus.PC == prev_pc);
    assign stall_nxt = stall_cnt + SW'(1);
    assign halt_hit  = pc_match && (stall_nxt == SW'(STALL_LIMIT));
    assign tmo_hit   = (budget != '0) && (cnt_nxt == budget);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= S_IDLE;
            budget       <= '0;
            hold_cnt     <= '0;
            stall_cnt    <= '0;
            prev_pc      <= '0;
            prev_vld     <= 1'b0;
            core_reset_r <= 1'b1;
            fwd_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            halted_r     <= 1'b0;
            timeout_r    <= 1'b0;
            cycle_cnt_r  <= '0;
        end else if (bus.ABORT) begin
            state        <= S_IDLE;
            core_reset_r <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            halted_r     <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    core_reset_r <= 1'b1;
                    if (bus.START) begin
                        state       <= S_RESET_HOLD;
                        fwd_r       <= bus.FWD_MODE;
                        budget      <= bus.MAX_CYCLES;
                        cycle_cnt_r <= '0;
                        halted_r    <= 1'b0;
                        timeout_r   <= 1'b0;
                        hold_cnt    <= '0;
                        busy_r      <= 1'b1;
                    end
                end
                S_RESET_HOLD: begin
                    if (hold_cnt == HW'(RST_HOLD - 1)) begin
                        state        <= S_RUN;
                        core_reset_r <= 1'b0;
                        stall_cnt    <= '0;
                        prev_vld     <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    cycle_cnt_r <= cnt_nxt;
                    prev_pc     <= bus.PC;
                    prev_vld    <= 1'b1;
                    stall_cnt   <= pc_match ? stall_nxt : '0;
                    // Halt wins a tie with the budget edge.
                    if (halt_hit || tmo_hit) begin
                        state        <= S_DONE;
                        core_reset_r <= 1'b1;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        halted_r     <= halt_hit;
                        timeout_r    <= !halt_hit;
                    end
                end
                S_DONE: begin
                    if (!bus.START) begin
                        state  <= S_IDLE;
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    core_reset_r <= 1'b1;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CORE_RESET    = core_reset_r;
    assign bus.FORWARDING_EN = fwd_r;
    assign bus.BUSY          = busy_r;
    assign bus.DONE          = done_r;
    assign bus.HALTED        = halted_r;
    assign bus.TIMEOUT       = timeout_r;
    assign bus.CYCLE_COUNT   = cycle_cnt_r;
endmodule
